// File: rtl/mdio_link_manager.sv
// mdio_link_manager
// Shares one clause-22 MDIO controller between a host register-access port
// and an autonomous BMSR poller, and publishes link / autoneg status.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   host_*                  level-request host access port (ack is a 1-cycle pulse)
//   poll_enable             enables the periodic poll timer
//   mdio_*                  command/response handshake with the MDIO controller
//   link_up, an_complete    last polled BMSR[2] / BMSR[5]
//   status_valid            set after the first successful poll
//   link_change             1-cycle pulse when link_up toggles
//
// Optional feature macro: MDIO_TIMEOUT_EN adds a watchdog over ISSUE/WAIT_DONE
// that forces a completion with data 0 after TIMEOUT_CYCLES cycles.
module mdio_link_manager #(
    parameter int unsigned PHYADDR_LENGTH = 5,
    parameter int unsigned REGADDR_LENGTH = 5,
    parameter int unsigned DATA_LENGTH    = 16,
    parameter logic [PHYADDR_LENGTH-1:0] POLL_PHY_ADDRESS = PHYADDR_LENGTH'(1),
    parameter logic [REGADDR_LENGTH-1:0] POLL_REG_ADDRESS = REGADDR_LENGTH'(1),
    parameter int unsigned POLL_INTERVAL  = 1250000,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      host_req,
    input  logic                      host_write,
    input  logic [PHYADDR_LENGTH-1:0] host_phy_address,
    input  logic [REGADDR_LENGTH-1:0] host_reg_address,
    input  logic [DATA_LENGTH-1:0]    host_write_data,
    output logic                      host_ack,
    output logic [DATA_LENGTH-1:0]    host_read_data,
    output logic                      host_error,
    input  logic                      poll_enable,
    output logic                      mdio_read,
    output logic                      mdio_write,
    output logic [PHYADDR_LENGTH-1:0] mdio_phy_address,
    output logic [REGADDR_LENGTH-1:0] mdio_reg_address,
    output logic [DATA_LENGTH-1:0]    mdio_write_data,
    input  logic [DATA_LENGTH-1:0]    mdio_read_data,
    input  logic                      mdio_access_complete,
    input  logic                      mdio_busy,
    output logic                      link_up,
    output logic                      an_complete,
    output logic                      status_valid,
    output logic                      link_change
);

    localparam int unsigned TMR_W = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_INTERVAL - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESPOND} state_t;

    state_t                    state_q, state_d;
    logic                      owner_poll_q, owner_poll_d;
    logic                      op_write_q, op_write_d;
    logic                      rd_q, rd_d, wr_q, wr_d;
    logic [PHYADDR_LENGTH-1:0] phy_q, phy_d;
    logic [REGADDR_LENGTH-1:0] reg_q, reg_d;
    logic [DATA_LENGTH-1:0]    wdata_q, wdata_d;
    logic                      ack_q, ack_d;
    logic [DATA_LENGTH-1:0]    rdata_q, rdata_d;
    logic                      link_q, link_d, an_q, an_d, valid_q, valid_d, lchg_q, lchg_d;
    logic [TMR_W-1:0]          timer_q, timer_d;
    logic                      pend_q, pend_d, overdue_q, overdue_d;

    logic                      finish_c;
    logic                      timeout_c;
    logic [DATA_LENGTH-1:0]    resp_data_c;

`ifdef MDIO_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            err_q, err_d;

    // Watchdog expiry while a command is outstanding
    always_comb begin
        timeout_c = ((state_q == ISSUE) || (state_q == WAIT_DONE)) && (wdog_q == WD_LAST);
    end

    assign host_error = err_q;
`else
    always_comb begin
        timeout_c = 1'b0;
    end

    assign host_error = 1'b0;
`endif

    // Next-state logic: timer, arbitration, command handshake, completion
    always_comb begin
        state_d      = state_q;
        owner_poll_d = owner_poll_q;
        op_write_d   = op_write_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        phy_d        = phy_q;
        reg_d        = reg_q;
        wdata_d      = wdata_q;
        ack_d        = 1'b0;
        rdata_d      = rdata_q;
        link_d       = link_q;
        an_d         = an_q;
        valid_d      = valid_q;
        lchg_d       = 1'b0;
        timer_d      = timer_q;
        pend_d       = pend_q;
        overdue_d    = overdue_q;
        finish_c     = 1'b0;
        resp_data_c  = '0;
`ifdef MDIO_TIMEOUT_EN
        wdog_d       = wdog_q;
        err_d        = 1'b0;
`endif

        // Poll timer; a wrap with a request already pending is absorbed
        if (!poll_enable) begin
            timer_d = '0;
        end else if (timer_q == TMR_LAST) begin
            timer_d = '0;
            pend_d  = 1'b1;
        end else begin
            timer_d = timer_q + TMR_W'(1);
        end

        case (state_q)
            IDLE: begin
                // Registered poll_pending: the host wins unless the poller is overdue
                if (pend_q && (overdue_q || !host_req)) begin
                    owner_poll_d = 1'b1;
                    op_write_d   = 1'b0;
                    rd_d         = 1'b1;
                    wr_d         = 1'b0;
                    phy_d        = POLL_PHY_ADDRESS;
                    reg_d        = POLL_REG_ADDRESS;
                    overdue_d    = 1'b0;
                    state_d      = ISSUE;
                end else if (host_req) begin
                    owner_poll_d = 1'b0;
                    op_write_d   = host_write;
                    rd_d         = !host_write;
                    wr_d         = host_write;
                    phy_d        = host_phy_address;
                    reg_d        = host_reg_address;
                    wdata_d      = host_write_data;
                    if (pend_q) begin
                        overdue_d = 1'b1;
                    end
                    state_d      = ISSUE;
                end
`ifdef MDIO_TIMEOUT_EN
                wdog_d = '0;
`endif
            end
            ISSUE: begin
                if (mdio_busy) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (mdio_access_complete) begin
                    finish_c    = 1'b1;
                    resp_data_c = mdio_read_data;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef MDIO_TIMEOUT_EN
        if ((state_q == ISSUE) || (state_q == WAIT_DONE)) begin
            wdog_d = wdog_q + WD_W'(1);
        end
`endif
        // Watchdog expiry overrides any normal completion with data 0
        if (timeout_c) begin
            finish_c    = 1'b1;
            resp_data_c = '0;
        end

        // Completion: results are registered so they appear during RESPOND
        if (finish_c) begin
            state_d = RESPOND;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            if (!owner_poll_q) begin
                ack_d = 1'b1;
`ifdef MDIO_TIMEOUT_EN
                err_d = timeout_c;
`endif
                if (!op_write_q) begin
                    rdata_d = resp_data_c;
                end
            end else begin
                link_d  = resp_data_c[2];
                an_d    = resp_data_c[5];
                valid_d = !timeout_c;
                lchg_d  = (resp_data_c[2] != link_q);
                pend_d  = 1'b0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            owner_poll_q <= 1'b0;
            op_write_q   <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            phy_q        <= '0;
            reg_q        <= '0;
            wdata_q      <= '0;
            ack_q        <= 1'b0;
            rdata_q      <= '0;
            link_q       <= 1'b0;
            an_q         <= 1'b0;
            valid_q      <= 1'b0;
            lchg_q       <= 1'b0;
            timer_q      <= '0;
            pend_q       <= 1'b0;
            overdue_q    <= 1'b0;
`ifdef MDIO_TIMEOUT_EN
            wdog_q       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_poll_q <= owner_poll_d;
            op_write_q   <= op_write_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            phy_q        <= phy_d;
            reg_q        <= reg_d;
            wdata_q      <= wdata_d;
            ack_q        <= ack_d;
            rdata_q      <= rdata_d;
            link_q       <= link_d;
            an_q         <= an_d;
            valid_q      <= valid_d;
            lchg_q       <= lchg_d;
            timer_q      <= timer_d;
            pend_q       <= pend_d;
            overdue_q    <= overdue_d;
`ifdef MDIO_TIMEOUT_EN
            wdog_q       <= wdog_d;
            err_q        <= err_d;
`endif
        end
    end

    assign host_ack         = ack_q;
    assign host_read_data   = rdata_q;
    assign mdio_read        = rd_q;
    assign mdio_write       = wr_q;
    assign mdio_phy_address = phy_q;
    assign mdio_reg_address = reg_q;
    assign mdio_write_data  = wdata_q;
    assign link_up          = link_q;
    assign an_complete      = an_q;
    assign status_valid     = valid_q;
    assign link_change      = lchg_q;

endmodule
